// File: rtl/nibble_serial_adder_ctrl_if.sv
// nibble_serial_adder_ctrl_if: request/result bundle between a wide-add requester and the nibble sequencer.
interface nibble_serial_adder_ctrl_if #(parameter int WIDTH = 16);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  modport master (output start, a, b, c_in, input busy, done, sum, c_out);
  modport slave (input start, a, b, c_in, output busy, done, sum, c_out);
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit add sequenced over one shared 4-bit adder, LSB nibble first.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input logic                      clk,
  input logic                      rst,
  nibble_serial_adder_ctrl_if.slave bus
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, sum_q, sum_d;
  logic             carry_q, carry_d, c_out_q, c_out_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  // The single shared 4-bit adder: current nibble pair plus the registered carry.
  assign {nib_cout, nib_sum} = {1'b0, op_a_q[4*idx_q +: 4]} + {1'b0, op_b_q[4*idx_q +: 4]} + {4'b0, carry_q};
  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: if (bus.start) begin
        op_a_d  = bus.a;
        op_b_d  = bus.b;
        carry_d = bus.c_in;
        idx_d   = '0;
        sum_d   = '0;
        c_out_d = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[4*idx_q +: 4] = nib_sum;
        carry_d             = nib_cout;
        if (idx_q == IW'(NIB - 1)) begin
          c_out_d = nib_cout;
          state_d = DONE;
        end else idx_d = idx_q + IW'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      idx_q   <= idx_d;
    end
  end
  assign bus.busy  = state_q == RUN;
  assign bus.done  = state_q == DONE;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: scoreboard bench driving a WIDTH=16 and a WIDTH=4 sequencer.
module tb_nibble_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  nibble_serial_adder_ctrl_if #(.WIDTH(16)) b16 ();
  nibble_serial_adder_ctrl_if #(.WIDTH(4))  b4 ();
  nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));
  nibble_serial_adder_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));
  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] q16[$];
  logic [4:0]  q4[$];
  logic [16:0] e16;
  logic [4:0]  e4;
  int ncyc = 0, bc16 = 0, bc4 = 0, last16 = -1, last4 = -1;
  bit pd16 = 0, pd4 = 0, spc16 = 0, spc4 = 0;
  logic [15:0] ra, rb;
  logic rc;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Monitor: pops the scoreboard whenever a DUT raises done.
  always @(negedge clk) begin
    ncyc++;
    if (rst) begin
      bc16 = 0; bc4 = 0; pd16 = 0; pd4 = 0;
    end else begin
      if (b16.busy) bc16++;
      if (b4.busy) bc4++;
      if (b16.done) begin
        chk("done16_single", 32'(pd16), 0);
        chk("busy16_len", bc16, 4);
        bc16 = 0;
        if (q16.size() == 0) chk("done16_unexpected", 1, 0);
        else begin
          e16 = q16.pop_front();
          chk("sum16", {b16.c_out, b16.sum}, 32'(e16));
        end
        if (spc16 && last16 >= 0) chk("spacing16", ncyc - last16, 6);
        last16 = ncyc;
      end
      if (b4.done) begin
        chk("done4_single", 32'(pd4), 0);
        chk("busy4_len", bc4, 1);
        bc4 = 0;
        if (q4.size() == 0) chk("done4_unexpected", 1, 0);
        else begin
          e4 = q4.pop_front();
          chk("sum4", {b4.c_out, b4.sum}, 32'(e4));
        end
        if (spc4 && last4 >= 0) chk("spacing4", ncyc - last4, 3);
        last4 = ncyc;
      end
      pd16 = b16.done;
      pd4  = b4.done;
    end
  end
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c, input logic [16:0] exp);
    @(negedge clk);
    b16.a = a; b16.b = b; b16.c_in = c; b16.start = 1'b1;
    q16.push_back(exp);
    @(negedge clk);
    b16.start = 1'b0;
  endtask
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c, input logic [4:0] exp);
    @(negedge clk);
    b4.a = a; b4.b = b; b4.c_in = c; b4.start = 1'b1;
    q4.push_back(exp);
    @(negedge clk);
    b4.start = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && (q16.size() > 0 || q4.size() > 0); i++) @(negedge clk);
    #1;
    chk("drain16", q16.size(), 0);
    chk("drain4", q4.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    b16.start = 0; b16.a = '0; b16.b = '0; b16.c_in = 0;
    b4.start = 0; b4.a = '0; b4.b = '0; b4.c_in = 0;
    #1 rst = 1'b1;
    #2;
    chk("rst16_outs", {b16.busy, b16.done, b16.c_out, b16.sum}, 0);
    chk("rst4_outs", {b4.busy, b4.done, b4.c_out, b4.sum}, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    op16(16'hFFFF, 16'h0001, 1'b0, 17'h1_0000);
    drain();
    repeat (3) @(negedge clk);
    chk("hold16", {b16.c_out, b16.sum}, 32'h1_0000);
    op16(16'h1234, 16'h4321, 1'b1, 17'h0_5556);
    drain();
    op16(16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF);
    drain();
    // Operands and start wiggle while busy; only the original request may complete.
    @(negedge clk);
    b16.a = 16'h00F0; b16.b = 16'h0010; b16.c_in = 0; b16.start = 1'b1;
    q16.push_back(17'h0_0100);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      b16.a = 16'($urandom); b16.b = 16'($urandom); b16.c_in = 1'($urandom); b16.start = (i % 2 == 0);
    end
    @(negedge clk);
    b16.start = 1'b0;
    drain();
    repeat (8) @(negedge clk);
    chk("no_relaunch16", 32'(b16.busy), 0);
    chk("ignored16_sum", {b16.c_out, b16.sum}, 32'h0_0100);
    op16(16'h1111, 16'h2222, 1'b0, 17'h0_3333);
    @(posedge clk);
    #3;
    chk("partial16_busy", 32'(b16.busy), 1);
    chk("partial16_sum", 32'(b16.sum), 32'h0003);
    rst = 1'b1;
    #1;
    chk("abort16_busy", 32'(b16.busy), 0);
    chk("abort16_done", 32'(b16.done), 0);
    chk("abort16_sum", {b16.c_out, b16.sum}, 0);
    void'(q16.pop_back());
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (8) @(negedge clk);
    op16(16'h0001, 16'h0001, 1'b0, 17'h0_0002);
    drain();
    spc16 = 1; last16 = -1;
    for (int k = 0; k < 200; k++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      b16.a = ra; b16.b = rb; b16.c_in = rc; b16.start = 1'b1;
      q16.push_back(17'(ra) + 17'(rb) + 17'(rc));
      repeat (6) @(negedge clk);
    end
    b16.start = 1'b0;
    drain();
    spc16 = 0;
    op4(4'hF, 4'h1, 1'b1, 5'h11);
    drain();
    op4(4'h7, 4'h8, 1'b0, 5'h0F);
    drain();
    op4(4'hF, 4'hF, 1'b1, 5'h1F);
    drain();
    spc4 = 1; last4 = -1;
    for (int k = 0; k < 200; k++) begin
      ra = 16'($urandom_range(15)); rb = 16'($urandom_range(15)); rc = 1'($urandom);
      b4.a = ra[3:0]; b4.b = rb[3:0]; b4.c_in = rc; b4.start = 1'b1;
      q4.push_back(5'(ra[3:0]) + 5'(rb[3:0]) + 5'(rc));
      repeat (3) @(negedge clk);
    end
    b4.start = 1'b0;
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
